// File: rtl/iter_barrel_shifter.sv
// Multi-cycle barrel shifter: resolves BITS_PER_CYCLE shift-amount bits per clock behind valid/ready handshakes.
// Define SHIFTER_ROTATE_EN to build rotate-right for mode 11; otherwise mode 11 behaves exactly as SRL.
module iter_barrel_shifter #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] FIRST_MASK = SHW'((1 << BITS_PER_CYCLE) - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROR} shiftMode_e;

    state_e           state_q, state_d;
    shiftMode_e       mode_q, mode_d, capMode;
    logic             readyEn_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [SHW-1:0]   stepMask_q, stepMask_d;
    logic [SHW-1:0]   nextMask;
    logic [SHW-1:0]   cycShift;
    logic [WIDTH-1:0] stepResult;
    logic             overshift;
`ifdef SHIFTER_ROTATE_EN
    logic [2*WIDTH-1:0] rotWide;
`endif

    assign in_ready  = readyEn_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign nextMask  = stepMask_q << BITS_PER_CYCLE;

    // The stages of one step merge into a single shift by the masked amount bits; fills compose additively.
    always_comb begin
        cycShift = amt_q & stepMask_q;
`ifdef SHIFTER_ROTATE_EN
        rotWide  = {data_q, data_q} >> cycShift;
`endif
        case (mode_q)
            MODE_SLL: stepResult = data_q << cycShift;
            MODE_SRA: stepResult = $signed(data_q) >>> cycShift;
`ifdef SHIFTER_ROTATE_EN
            MODE_ROR: stepResult = rotWide[WIDTH-1:0];
`endif
            default:  stepResult = data_q >> cycShift;
        endcase
    end

    always_comb begin
        capMode = shiftMode_e'(mode);
`ifndef SHIFTER_ROTATE_EN
        if (capMode == MODE_ROR) begin
            capMode = MODE_SRL;
        end
`endif
        overshift = |(B >> SHW);
    end

    // Overshift is folded into the captured operand so the iteration runs unchanged with a zero amount.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        data_d     = data_q;
        amt_d      = amt_q;
        stepMask_d = stepMask_q;
        out_d      = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d    = BUSY;
                    mode_d     = capMode;
                    stepMask_d = FIRST_MASK;
                    if (overshift && (capMode != MODE_ROR)) begin
                        data_d = (capMode == MODE_SRA) ? {WIDTH{A[WIDTH-1]}} : '0;
                        amt_d  = '0;
                    end else begin
                        data_d = A;
                        amt_d  = B[SHW-1:0];
                    end
                end
            end
            BUSY: begin
                data_d     = stepResult;
                stepMask_d = nextMask;
                if (nextMask == '0) begin
                    state_d = DONE;
                    out_d   = stepResult;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_SLL;
            readyEn_q  <= 1'b0;
            data_q     <= '0;
            amt_q      <= '0;
            stepMask_q <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            readyEn_q  <= 1'b1;
            data_q     <= data_d;
            amt_q      <= amt_d;
            stepMask_q <= stepMask_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: doc/iter_barrel_shifter.md
Name: iter_barrel_shifter

Overview:
- Parametrised multi-cycle barrel shifter. Supports logical left, logical right, arithmetic right and (optionally) rotate right.
- Replaces the fixed 32-bit combinational SRL/SRA units in the ALU datapath.
- Resolves BITS_PER_CYCLE bits of the shift amount per clock, so area can be traded for latency.
- Uses a valid/ready handshake on input and output; the ALU controller can stall either side.

Parameters:
- WIDTH, 32: data width in bits; must be a power of two, 8..64.
- BITS_PER_CYCLE, 1: shift-amount bits resolved per cycle, 1..SHW, where SHW = clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/command valid
- in_ready  output  1  block can accept a command
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- A  input  WIDTH  data operand
- B  input  WIDTH  shift amount; full word, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  shift result
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0 while rst_n=0 then 1 from first clock after release, out_valid=0, out=0, busy=0. Reset mid-operation aborts the job; no result is ever presented.
- NSTEP = ceil(SHW/BITS_PER_CYCLE). Latency is fixed and independent of B and mode.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge t, capture A, mode, B and go to BUSY with step=0.
- BUSY: in_ready=0. Each cycle, apply stages k = step*BITS_PER_CYCLE .. min(SHW, (step+1)*BITS_PER_CYCLE)-1. Stage k shifts by 2^k if amount bit k=1. After NSTEP cycles go to DONE. out_valid rises after edge t+NSTEP.
- DONE: out_valid=1; out holds stable until out_ready=1. On out_valid&&out_ready go to IDLE; out_valid drops next edge, out retains its last value.
- No overlap: a new command can only be accepted in IDLE, one cycle after the handshake completes. A single job occupies NSTEP+2 cycles minimum at full throughput.
- Fill rules:
  - SLL and SRL fill with 0.
  - SRA fills with captured A[WIDTH-1].
  - ROR wraps the bits shifted out of the LSB into the MSB.
- Overshift (B >= WIDTH), decided at capture:
  - SLL/SRL result = 0.
  - SRA result = all copies of A[WIDTH-1].
  - ROR uses B mod WIDTH.
  - Latency is unchanged for overshift.
- B = 0: out = A, after the normal latency.
- in_valid while not IDLE is ignored; the source must hold it until in_ready.
- Operands are registered at capture; changes to A, B or mode during BUSY have no effect.
- busy = (state != IDLE).

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined: mode 11 performs rotate right as specified above.
- Undefined: no rotate hardware is built; mode 11 executes exactly as SRL, including overshift → 0.

Test Plan:
- WIDTH=32, BPC=1, mode=SRL/SRA, A=80000000, B=0..5 → SRL 80000000, 40000000, 20000000, 10000000, 08000000, 04000000. SRA 80000000, C0000000, E0000000, F0000000, F8000000, FC000000. out_valid exactly 5 cycles after accept.
- A=0000FF00, B=0..8, SRL and SRA → identical results, 0000FF00 down to 000000FF. SLL B=8 → 00FF0000.
- Overshift, A=80000000: B=32 → SRL 00000000, SRA FFFFFFFF. A=0000FF00, B=FFFFFFFF → SRA 00000000. ROR (macro on), A=00000001, B=33 → 80000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out stable, in_ready=0, second in_valid ignored. Release out_ready → next command accepted in IDLE.
- Reset mid-BUSY: assert rst_n=0 at step 2 → out_valid=0, out=0 immediately. After release, a fresh job with A=0000FF00, B=4, SRL → 00000FF0.
- Parameter sweep: WIDTH=8, BPC=3, A=96, B=3, SRA → F2 with 1-cycle latency. Macro off, mode=11, A=80000000, B=1 → 40000000.
